// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// mult/div take WIDTH+2 cycles from accept to done; stall is raised for MDU ops seen while busy.
module alu_ctrl_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_alu_op,
  input  logic [5:0]       i_funct,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [3:0]       o_ctrl,
  output logic             o_illegal,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_mf_data
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_count;
  logic [WIDTH-1:0]  r_hi, r_lo;
  logic [WIDTH-1:0]  r_wh, r_wl, r_opnd;
  logic              r_div, r_neg_q, r_neg_r, r_dz, r_done;
  logic              w_done_nxt;

  logic              w_is_mdu, w_issue, w_start, w_mt_hi, w_mt_lo, w_signed, w_div;
  logic              w_a_neg, w_b_neg;
  logic [WIDTH-1:0]  w_a_mag, w_b_mag;
  logic [WIDTH:0]    w_madd;
  logic [WIDTH+1:0]  w_dshift, w_ddiff;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]  w_quo_fix, w_rem_fix;

  // Decode
  always_comb begin
    o_ctrl    = 4'b1111;
    o_illegal = 1'b1;
    w_is_mdu  = 1'b0;
    unique case (i_alu_op)
      2'b00: begin o_ctrl = 4'b0010; o_illegal = 1'b0; end
      2'b01: begin o_ctrl = 4'b0110; o_illegal = 1'b0; end
      2'b10: begin
        case (i_funct)
          6'b100000, 6'b100001: begin o_ctrl = 4'b0010; o_illegal = 1'b0; end
          6'b100010, 6'b100011: begin o_ctrl = 4'b0110; o_illegal = 1'b0; end
          6'b100100: begin o_ctrl = 4'b0000; o_illegal = 1'b0; end
          6'b100101: begin o_ctrl = 4'b0001; o_illegal = 1'b0; end
          6'b100110: begin o_ctrl = 4'b0011; o_illegal = 1'b0; end
          6'b100111: begin o_ctrl = 4'b1100; o_illegal = 1'b0; end
          6'b101010: begin o_ctrl = 4'b0111; o_illegal = 1'b0; end
          6'b101011: begin o_ctrl = 4'b1000; o_illegal = 1'b0; end
          6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010000, 6'b010001, 6'b010010, 6'b010011: begin
            o_illegal = 1'b0;
            w_is_mdu  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign o_busy   = (r_state != StIdle);
  assign o_stall  = i_valid & w_is_mdu & o_busy;
  assign w_issue  = i_valid & w_is_mdu & ~o_busy;
  assign w_start  = w_issue & (i_funct[5:2] == 4'b0110);
  assign w_mt_hi  = w_issue & (i_funct == 6'b010001);
  assign w_mt_lo  = w_issue & (i_funct == 6'b010011);
  assign w_signed = ~i_funct[0];
  assign w_div    = i_funct[1];

  assign w_a_neg = w_signed & i_a[WIDTH-1];
  assign w_b_neg = w_signed & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // One shift-add step: r_wh is the running high half, r_wl the multiplier shifting out
  assign w_madd   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_opnd} : {(WIDTH + 1){1'b0}});
  // One restoring divide step: r_wh is the partial remainder, r_wl the dividend/quotient
  assign w_dshift = {1'b0, r_wh, r_wl[WIDTH-1]};
  assign w_ddiff  = w_dshift - {2'b00, r_opnd};

  assign w_prod     = {r_wh, r_wl};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_wl : r_wl);
  assign w_rem_fix  = r_neg_r ? -r_wh : r_wh;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: if (w_start) w_state_nxt = StRun;
      StRun:  if (r_count == CntW'(WIDTH - 1)) w_state_nxt = StFix;
      StFix: begin
        w_state_nxt = StIdle;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_wh    <= '0;
      r_wl    <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      unique case (r_state)
        StIdle: begin
          if (w_start) begin
            r_div   <= w_div;
            r_wh    <= '0;
            r_wl    <= w_div ? w_a_mag : w_b_mag;
            r_opnd  <= w_div ? w_b_mag : w_a_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= w_div & (i_b == '0);
            r_count <= '0;
          end
          if (w_mt_hi) r_hi <= i_a;
          if (w_mt_lo) r_lo <= i_a;
        end
        StRun: begin
          r_count <= r_count + CntW'(1);
          if (r_div) begin
            r_wl <= {r_wl[WIDTH-2:0], ~w_ddiff[WIDTH+1]};
            r_wh <= w_ddiff[WIDTH+1] ? w_dshift[WIDTH-1:0] : w_ddiff[WIDTH-1:0];
          end else begin
            r_wh <= w_madd[WIDTH:1];
            r_wl <= {w_madd[0], r_wl[WIDTH-1:1]};
          end
        end
        StFix: begin
          if (r_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_mf_data = '0;
    if (i_alu_op == 2'b10 && !o_stall) begin
      if (i_funct == 6'b010000) o_mf_data = r_hi;
      if (i_funct == 6'b010010) o_mf_data = r_lo;
    end
  end

  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Bench for alu_ctrl_mdu: decode sweep, table-driven MDU ops with a result scoreboard,
// and hand sequences for stall, mt* while busy, and reset abort.
module tb_alu_ctrl_mdu;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n, valid;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] ia, ib;
  logic [3:0]   ctrl;
  logic         illegal, busy, stall, done;
  logic [W-1:0] hi, lo, mf_data;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_alu_op(alu_op), .i_funct(funct), .i_valid(valid),
    .i_a(ia), .i_b(ib), .o_ctrl(ctrl), .o_illegal(illegal), .o_busy(busy), .o_stall(stall),
    .o_done(done), .o_hi(hi), .o_lo(lo), .o_mf_data(mf_data)
  );

  typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; } exp_t;
  typedef struct { logic [5:0] fn; logic [W-1:0] a; logic [W-1:0] b; exp_t e; } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] fn);
    case (op)
      2'b00: return 5'b0_0010;
      2'b01: return 5'b0_0110;
      2'b10: begin
        case (fn)
          6'b100000, 6'b100001: return 5'b0_0010;
          6'b100010, 6'b100011: return 5'b0_0110;
          6'b100100: return 5'b0_0000;
          6'b100101: return 5'b0_0001;
          6'b100110: return 5'b0_0011;
          6'b100111: return 5'b0_1100;
          6'b101010: return 5'b0_0111;
          6'b101011: return 5'b0_1000;
          6'b011000, 6'b011001, 6'b011010, 6'b011011,
          6'b010000, 6'b010001, 6'b010010, 6'b010011: return 5'b0_1111;
          default: return 5'b1_1111;
        endcase
      end
      default: return 5'b1_1111;
    endcase
  endfunction

  function automatic exp_t model(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      pa, pb;
    logic [63:0] p;
    int          sa, sb;
    e.hi = '0;
    e.lo = '0;
    case (fn)
      6'b011000: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      6'b011001: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == '0) begin
          e.lo = '1;
          e.hi = a;
        end else if (fn == 6'b011010 && a == 32'h8000_0000 && b == '1) begin
          e.lo = a;
          e.hi = '0;
        end else if (fn == 6'b011010) begin
          sa = $signed(a);
          sb = $signed(b);
          e.lo = sa / sb;
          e.hi = sa % sb;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input exp_t e);
    alu_op = 2'b10;
    funct  = fn;
    ia     = a;
    ib     = b;
    valid  = 1'b1;
    #1;
    chk("stall at issue", {63'd0, stall}, 64'd0);
    if (push) sb_q.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int   busy_n = 0;
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    chk({name, " done seen"}, {63'd0, seen}, 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (seen) begin
        chk({name, " busy cycles"}, 64'(busy_n), 64'(W + 1));
        chk({name, " hi"}, {32'd0, hi}, {32'd0, e.hi});
        chk({name, " lo"}, {32'd0, lo}, {32'd0, e.lo});
      end
    end
  endtask

  vec_t tbl[10];
  exp_t nul;

  initial begin
    nul.hi = '0;
    nul.lo = '0;
    tbl[0] = '{6'b011000, 32'hFFFF_FFFD, 32'd7, '{32'hFFFF_FFFF, 32'hFFFF_FFEB}};
    tbl[1] = '{6'b011001, 32'hFFFF_FFFD, 32'd7, '{32'h0000_0006, 32'hFFFF_FFEB}};
    tbl[2] = '{6'b011011, 32'd100, 32'd7, '{32'h0000_0002, 32'h0000_000E}};
    tbl[3] = '{6'b011010, 32'hFFFF_FFF9, 32'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD}};
    tbl[4] = '{6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, '{32'h0, 32'h8000_0000}};
    tbl[5] = '{6'b011010, 32'h0000_1234, 32'd0, '{32'h0000_1234, 32'hFFFF_FFFF}};
    tbl[6] = '{6'b011000, 32'h8000_0000, 32'h8000_0000, '{32'h4000_0000, 32'h0}};
    tbl[7] = '{6'b011011, 32'hFFFF_FFFF, 32'd1, '{32'h0, 32'hFFFF_FFFF}};
    tbl[8] = '{6'b011010, 32'd7, 32'hFFFF_FFFE, '{32'h0000_0001, 32'hFFFF_FFFD}};
    tbl[9] = '{6'b011010, 32'hFFFF_FFF8, 32'd0, '{32'hFFFF_FFF8, 32'hFFFF_FFFF}};

    rst_n = 1'b0; valid = 1'b0; alu_op = 2'b00; funct = '0; ia = '0; ib = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);

    for (int op = 0; op < 4; op++) begin
      for (int fn = 0; fn < 64; fn++) begin
        alu_op = 2'(op);
        funct  = 6'(fn);
        #1;
        chk($sformatf("decode op%0d fn%02h", op, fn), {59'd0, illegal, ctrl},
            {59'd0, ref_dec(2'(op), 6'(fn))});
      end
    end

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].fn, tbl[i].a, tbl[i].b, 1'b1, tbl[i].e);
      wait_done($sformatf("vec%0d", i));
      if (i == 0) begin
        @(negedge clk);
        chk("done single pulse", {63'd0, done}, 64'd0);
      end
    end

    for (int i = 0; i < 6; i++) begin
      logic [5:0]   fn;
      logic [W-1:0] a, b;
      fn = {4'b0110, 2'($urandom_range(0, 3))};
      a  = $urandom;
      b  = (i % 2 == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      issue(fn, a, b, 1'b1, model(fn, a, b));
      wait_done($sformatf("rand%0d", i));
    end

    // Stall sequence: mult 3*5 in flight, mthi and mflo presented while busy
    issue(6'b011000, 32'd3, 32'd5, 1'b0, nul);
    repeat (4) @(posedge clk);
    #1;
    funct = 6'b010001; ia = 32'hDEAD_BEEF; valid = 1'b1;
    #1;
    chk("mthi stall", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1;
    funct = 6'b010010;
    #1;
    chk("mflo stall", {63'd0, stall}, 64'd1);
    chk("mflo gated", {32'd0, mf_data}, 64'd0);
    begin
      bit seen = 0;
      bit st_ok = 1;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1;
        else if (!stall) st_ok = 0;
      end
      chk("stall seq done", {63'd0, seen}, 64'd1);
      chk("stall held until done", {63'd0, st_ok}, 64'd1);
    end
    chk("stall in done cycle", {63'd0, stall}, 64'd0);
    chk("mflo data", {32'd0, mf_data}, 64'd15);
    chk("hi after stalled mthi", {32'd0, hi}, 64'd0);
    funct = 6'b010011; ia = 32'h55;
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("mtlo in done cycle", {32'd0, lo}, 64'h55);
    chk("hi unchanged by mtlo", {32'd0, hi}, 64'd0);

    issue(6'b010001, 32'h0000_ABCD, 32'd0, 1'b0, nul);
    chk("mthi write", {32'd0, hi}, 64'h0000_ABCD);
    funct = 6'b010000;
    #1;
    chk("mfhi data", {32'd0, mf_data}, 64'h0000_ABCD);

    // Reset abort during a divide
    issue(6'b011010, 32'd1000, 32'd3, 1'b0, nul);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort hi", {32'd0, hi}, 64'd0);
    chk("abort lo", {32'd0, lo}, 64'd0);
    begin
      bit any_done = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) any_done = 1;
      end
      chk("no done after abort", {63'd0, any_done}, 64'd0);
    end
    issue(6'b011011, 32'd9, 32'd3, 1'b1, '{32'd0, 32'd3});
    wait_done("divu after abort");

    chk("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_mdu.md
# alu_ctrl_mdu

Parametrised successor to the single-cycle ALU control decoder. It performs the full R-type ALU control decode, covering the original five operations plus unsigned, xor, nor and sltu. It adds an iterative multiply/divide unit (MDU) with HI/LO registers and a busy/stall handshake to the hazard logic. It sits in the EX stage beside the ALU, and its stall output feeds the pipeline hazard logic.

## Interface
- WIDTH, 32: operand/HI/LO width; must be ≥4 and even.
- clk  in  1: clock; all state updates on rising edge.
- rst_n  in  1: synchronous, active-low reset.
- alu_op  in  2: main-control ALU op class.
- funct  in  6: instruction funct field.
- valid  in  1: instruction in EX is real (not a bubble).
- a  in  WIDTH: rs operand.
- b  in  WIDTH: rt operand.
- ctrl  out  4: ALU control code (combinational).
- illegal  out  1: decode miss (combinational).
- busy  out  1: MDU iterating (registered).
- stall  out  1: MDU op presented while busy (combinational).
- done  out  1: one-cycle pulse; HI/LO just updated by mult/div.
- hi, lo  out  WIDTH: HI/LO registers.
- mf_data  out  WIDTH: mfhi→hi, mflo→lo, else 0 (combinational).

## Operation
- Decode (pure combinational, no latches; every path assigns ctrl and illegal):
  - alu_op 00→0010 (add); 01→0110 (sub); 11→ctrl 1111, illegal=1.
  - alu_op 10, by funct: 100000/100001→0010; 100010/100011→0110; 100100→0000; 100101→0001; 100110→0011; 100111→1100; 101010→0111; 101011→1000.
  - MDU functs (below) give ctrl 1111, illegal=0.
  - Any other funct: ctrl 1111, illegal=1.
- MDU functs (alu_op=10 only): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
- Issue: an MDU op is issued when valid=1 and busy=0; stall = valid & MDU-funct & busy.
- FSM states:
  - IDLE→RUN on an issued mult/multu/div/divu. Operands latched; signed ops latch magnitudes and record signs; count=0.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) iteration per edge. After the WIDTH-th iteration → FIX.
  - FIX: sign correction, HI/LO written, done=1 for this cycle; →IDLE.
- Results:
  - mult/multu: {hi,lo} = 2·WIDTH-bit product.
  - div/divu: lo = quotient, hi = remainder; quotient sign = sa^sb, remainder sign = sa.
  - Signed MIN/−1: lo=MIN, hi=0, no trap.
  - Divide by zero: lo = all-ones, hi = a (signed ops: raw a), same latency, no flag.
- mthi/mtlo: when issued, write a to hi/lo on that edge in one cycle; busy stays 0.
- mfhi/mflo: mf_data is combinational and reflects the current register. While busy it is stall-gated.
- A stalled op (busy=1) has no effect. The pipeline re-presents it.
- Arithmetic is modulo WIDTH per half; no overflow outputs.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, hi=lo=0, busy=0, done=0, count=0. This aborts any in-flight op with no HI/LO update.
- Accept edge E0 → busy=1 from E0 through E(WIDTH+1). Iterations occur at E1..E_WIDTH, FIX at E(WIDTH+1).
- After E(WIDTH+1): busy=0, done=1 for exactly one cycle, and hi/lo hold the new values.
- A new MDU op is accepted in the done cycle (back-to-back allowed). stall is 0 in that cycle.
- A non-MDU instruction never stalls and never disturbs the FSM.
- Decode outputs change in the same cycle as inputs, with zero latency.

## Test plan
- Decode sweep: all 4 alu_op × 64 funct → ctrl/illegal exactly per table; e.g. alu_op=10, funct=100111 → ctrl=1100, illegal=0; funct=000111 → 1111, illegal=1.
- WIDTH=32, mult a=FFFFFFFD, b=7 → busy for 33 cycles, done pulse once, hi=FFFFFFFF, lo=FFFFFFEB; then multu with the same operands → hi=00000006, lo=FFFFFFEB.
- divu 100/7 → lo=0000000E, hi=00000002. div −7/2 → lo=FFFFFFFD, hi=FFFFFFFF. div 80000000/FFFFFFFF → lo=80000000, hi=0.
- div a=1234, b=0 → after 33 cycles lo=FFFFFFFF, hi=00001234.
- mult in flight; present mflo with valid=1 at cycle 5 → stall=1 until done; mthi while busy → hi unchanged. In the done cycle, issue mtlo a=55 → lo=55 next edge.
- rst_n low for one edge at iteration 10 of div → busy=0, hi=lo=0, no done pulse. A following divu 9/3 → lo=3, hi=0.
